// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
// Digit count and counter width are derived per instance from W and D.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_W = 16;
    localparam int DEFAULT_D = 4;
    localparam int DEFAULT_N = DEFAULT_W / DEFAULT_D;

    function automatic int digit_count(input int w, input int d);
        return w / d;
    endfunction

    // A single-digit configuration still needs a one-bit counter.
    function automatic int counter_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit widths_ok(input int w, input int d);
        return (d >= 1) && (d <= w) && ((w % d) == 0);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The master drives operands and consumes results; the slave is the subtractor.
interface serial_subtractor_if #(
    parameter int W = 16
);
    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_in_a;
    logic [W-1:0] io_in_b;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_out_d;
    logic         io_out_borrow;
    logic         io_out_zero;

    modport master (
        output io_in_valid, io_in_a, io_in_b, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_d, io_out_borrow, io_out_zero
    );

    modport slave (
        input  io_in_valid, io_in_a, io_in_b, io_out_ready,
        output io_in_ready, io_out_valid, io_out_d, io_out_borrow, io_out_zero
    );
endinterface

// File: rtl/serial_subtractor_digit_subtractor.sv
// One D-bit subtract-with-borrow slice; the top reuses a single copy every cycle.
module digit_subtractor #(
    parameter int D = 4
) (
    input  logic [D-1:0] io_in_a,
    input  logic [D-1:0] io_in_b,
    input  logic         io_in_bin,
    output logic [D-1:0] io_out_d,
    output logic         io_out_bout
);
    logic [D:0] diff;

    // Bit D of the widened difference goes high exactly when the slice underflows.
    assign diff        = {1'b0, io_in_a} - {1'b0, io_in_b} - {{D{1'b0}}, io_in_bin};
    assign io_out_d    = diff[D-1:0];
    assign io_out_bout = diff[D];
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned a - b: one D-bit digit per cycle, LSB first,
// with a registered borrow chain and valid/ready on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int D = DEFAULT_D
) (
    input logic               clock,
    input logic               reset,
    serial_subtractor_if.slave io
);
    localparam int N  = digit_count(W, D);
    localparam int CW = counter_width(N);
    localparam logic [CW-1:0] LAST_K = CW'(N - 1);

    generate
        if (!widths_ok(W, D)) begin : g_bad_widths
            $error("serial_subtractor: W must be a positive multiple of D");
        end
    endgenerate

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  d_reg;
    logic          borrow_reg;
    logic [CW-1:0] k;

    logic [D-1:0]  a_digit;
    logic [D-1:0]  b_digit;
    logic [D-1:0]  digit_d;
    logic          digit_bout;

    assign a_digit = a_reg[k*D +: D];
    assign b_digit = b_reg[k*D +: D];

    digit_subtractor #(.D(D)) u_digit (
        .io_in_a     (a_digit),
        .io_in_b     (b_digit),
        .io_in_bin   (borrow_reg),
        .io_out_d    (digit_d),
        .io_out_bout (digit_bout)
    );

    // Operands are captured once at acceptance, so later input changes cannot disturb a run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            d_reg      <= '0;
            borrow_reg <= 1'b0;
            k          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.io_in_valid) begin
                        a_reg      <= io.io_in_a;
                        b_reg      <= io.io_in_b;
                        d_reg      <= '0;
                        borrow_reg <= 1'b0;
                        k          <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    d_reg[k*D +: D] <= digit_d;
                    borrow_reg      <= digit_bout;
                    k               <= k + CW'(1);
                    if (k == LAST_K) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (io.io_out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.io_in_ready   = (state == IDLE);
    assign io.io_out_valid  = (state == DONE);
    assign io.io_out_d      = d_reg;
    assign io.io_out_borrow = borrow_reg;
    assign io.io_out_zero   = (d_reg == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed vectors, handshake corner cases, random ops
// against an arithmetic model, and a digit-width sweep over four instances.
module tb_serial_subtractor;

    logic clock;
    logic reset;

    int check_count = 0;
    int pass_count  = 0;

    serial_subtractor_if #(.W(16)) io4  ();
    serial_subtractor_if #(.W(16)) io1  ();
    serial_subtractor_if #(.W(16)) io8  ();
    serial_subtractor_if #(.W(16)) io16 ();

    serial_subtractor #(.W(16), .D(4))  dut    (.clock(clock), .reset(reset), .io(io4));
    serial_subtractor #(.W(16), .D(1))  dut_d1 (.clock(clock), .reset(reset), .io(io1));
    serial_subtractor #(.W(16), .D(8))  dut_d8 (.clock(clock), .reset(reset), .io(io8));
    serial_subtractor #(.W(16), .D(16)) dut_d16(.clock(clock), .reset(reset), .io(io16));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_d;
        logic        exp_borrow;
        logic        exp_zero;
    } vector_t;

    vector_t vectors[5];

    function automatic logic [16:0] model_sub(input logic [15:0] a, input logic [15:0] b);
        int diff;
        diff = int'(a) - int'(b);
        return {(a < b), 16'(diff & 32'hFFFF)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one operation on the D=4 instance and reports what appeared at out_valid.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input bit noisy,
                                  output logic [15:0] d, output logic bw, output logic zr,
                                  output int lat);
        @(negedge clock);
        io4.io_in_a     = a;
        io4.io_in_b     = b;
        io4.io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io4.io_in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clock);
            #1;
            if (io4.io_out_valid) begin
                lat = c;
            end else if (noisy) begin
                io4.io_in_valid = 1'($urandom);
                io4.io_in_a     = 16'($urandom);
                io4.io_in_b     = 16'($urandom);
            end
        end
        d  = io4.io_out_d;
        bw = io4.io_out_borrow;
        zr = io4.io_out_zero;
    endtask

    task automatic consume_output();
        @(negedge clock);
        io4.io_in_valid  = 1'b0;
        io4.io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io4.io_out_ready = 1'b0;
        check_output("consume_in_ready", 32'(io4.io_in_ready), 32'd1);
        check_output("consume_out_valid", 32'(io4.io_out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic        bw;
        logic        zr;
        int          lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] m;

        vectors[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
        vectors[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        vectors[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1};
        vectors[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vectors[4] = '{16'h00FF, 16'h0F00, 16'hF1FF, 1'b1, 1'b0};

        io4.io_in_valid = 0; io4.io_in_a = 0; io4.io_in_b = 0; io4.io_out_ready = 0;
        io1.io_in_valid = 0; io1.io_in_a = 0; io1.io_in_b = 0; io1.io_out_ready = 0;
        io8.io_in_valid = 0; io8.io_in_a = 0; io8.io_in_b = 0; io8.io_out_ready = 0;
        io16.io_in_valid = 0; io16.io_in_a = 0; io16.io_in_b = 0; io16.io_out_ready = 0;

        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_in_ready", 32'(io4.io_in_ready), 32'd1);
        check_output("reset_out_valid", 32'(io4.io_out_valid), 32'd0);
        check_output("reset_d", 32'(io4.io_out_d), 32'd0);
        check_output("reset_borrow", 32'(io4.io_out_borrow), 32'd0);
        check_output("reset_zero", 32'(io4.io_out_zero), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vectors[i].a, vectors[i].b, 1'b0, d, bw, zr, lat);
            check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check_output($sformatf("vec%0d_d", i), 32'(d), 32'(vectors[i].exp_d));
            check_output($sformatf("vec%0d_borrow", i), 32'(bw), 32'(vectors[i].exp_borrow));
            check_output($sformatf("vec%0d_zero", i), 32'(zr), 32'(vectors[i].exp_zero));
            consume_output();
        end

        // Input noise during RUN and DONE, plus three cycles of held-off out_ready.
        apply_stimulus(16'h5555, 16'h1111, 1'b1, d, bw, zr, lat);
        check_output("bp_latency", 32'(lat), 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            io4.io_in_valid = 1'($urandom);
            io4.io_in_a     = 16'($urandom);
            io4.io_in_b     = 16'($urandom);
            check_output("bp_out_valid", 32'(io4.io_out_valid), 32'd1);
            check_output("bp_in_ready", 32'(io4.io_in_ready), 32'd0);
            check_output("bp_d", 32'(io4.io_out_d), 32'h4444);
            check_output("bp_borrow", 32'(io4.io_out_borrow), 32'd0);
        end
        consume_output();

        // Asynchronous abort in the second RUN cycle, after one digit is already written.
        @(negedge clock);
        io4.io_in_a     = 16'hFFFF;
        io4.io_in_b     = 16'h0000;
        io4.io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io4.io_in_valid = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_output("abort_out_valid", 32'(io4.io_out_valid), 32'd0);
        check_output("abort_in_ready", 32'(io4.io_in_ready), 32'd1);
        check_output("abort_d", 32'(io4.io_out_d), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        apply_stimulus(16'h00FF, 16'h0F00, 1'b0, d, bw, zr, lat);
        check_output("post_abort_latency", 32'(lat), 32'd4);
        check_output("post_abort_d", 32'(d), 32'hF1FF);
        check_output("post_abort_borrow", 32'(bw), 32'd1);
        consume_output();

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = (i % 5 == 0) ? ra : 16'($urandom);
            m  = model_sub(ra, rb);
            apply_stimulus(ra, rb, 1'b1, d, bw, zr, lat);
            check_output("rand_latency", 32'(lat), 32'd4);
            check_output("rand_d", 32'(d), 32'(m[15:0]));
            check_output("rand_borrow", 32'(bw), 32'(m[16]));
            check_output("rand_zero", 32'(zr), 32'(m[15:0] == 16'h0));
            consume_output();
        end

        // Digit-width sweep: all four instances run the same operands side by side.
        for (int i = 0; i < 8; i++) begin
            int lat1, lat4, lat8, lat16;
            ra = 16'($urandom);
            rb = 16'($urandom);
            m  = model_sub(ra, rb);
            @(negedge clock);
            io1.io_in_a = ra;  io1.io_in_b = rb;  io1.io_in_valid = 1'b1;
            io4.io_in_a = ra;  io4.io_in_b = rb;  io4.io_in_valid = 1'b1;
            io8.io_in_a = ra;  io8.io_in_b = rb;  io8.io_in_valid = 1'b1;
            io16.io_in_a = ra; io16.io_in_b = rb; io16.io_in_valid = 1'b1;
            @(posedge clock);
            #1;
            io1.io_in_valid = 0; io4.io_in_valid = 0; io8.io_in_valid = 0; io16.io_in_valid = 0;
            lat1 = 0; lat4 = 0; lat8 = 0; lat16 = 0;
            for (int c = 1; c <= 24; c++) begin
                @(posedge clock);
                #1;
                if (io1.io_out_valid && lat1 == 0) lat1 = c;
                if (io4.io_out_valid && lat4 == 0) lat4 = c;
                if (io8.io_out_valid && lat8 == 0) lat8 = c;
                if (io16.io_out_valid && lat16 == 0) lat16 = c;
            end
            check_output("sweep_d1_latency", 32'(lat1), 32'd16);
            check_output("sweep_d4_latency", 32'(lat4), 32'd4);
            check_output("sweep_d8_latency", 32'(lat8), 32'd2);
            check_output("sweep_d16_latency", 32'(lat16), 32'd1);
            check_output("sweep_d1_d", 32'(io1.io_out_d), 32'(m[15:0]));
            check_output("sweep_d4_d", 32'(io4.io_out_d), 32'(m[15:0]));
            check_output("sweep_d8_d", 32'(io8.io_out_d), 32'(m[15:0]));
            check_output("sweep_d16_d", 32'(io16.io_out_d), 32'(m[15:0]));
            check_output("sweep_d1_borrow", 32'(io1.io_out_borrow), 32'(m[16]));
            check_output("sweep_d4_borrow", 32'(io4.io_out_borrow), 32'(m[16]));
            check_output("sweep_d8_borrow", 32'(io8.io_out_borrow), 32'(m[16]));
            check_output("sweep_d16_borrow", 32'(io16.io_out_borrow), 32'(m[16]));
            @(negedge clock);
            io1.io_out_ready = 1; io4.io_out_ready = 1; io8.io_out_ready = 1; io16.io_out_ready = 1;
            @(posedge clock);
            #1;
            io1.io_out_ready = 0; io4.io_out_ready = 0; io8.io_out_ready = 0; io16.io_out_ready = 0;
            check_output("sweep_d1_idle", 32'(io1.io_in_ready), 32'd1);
            check_output("sweep_d16_idle", 32'(io16.io_in_ready), 32'd1);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
